// File: rtl/sram_responder.sv
// Bus slave that converts cs/we requests into timed asynchronous-SRAM cycles.
// Returns a level acknowledge that stays high until the master releases cs.
module sram_responder #(
    parameter int unsigned SRAM_AW       = 16,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [15:0]        i_addr,
    input  logic [7:0]         i_dat,
    output logic [7:0]         o_dat,
    input  logic               i_we,
    input  logic               i_cs,
    output logic               o_ack,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [7:0]         o_sram_dq,
    input  logic [7:0]         i_sram_dq,
    output logic               o_sram_dq_oe,
    output logic               o_sram_ce_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_we_n
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_we, w_we_next;
    logic [SRAM_AW-1:0] r_addr, w_addr_next;
    logic [7:0]         r_dq, w_dq_next;
    logic [7:0]         r_dat, w_dat_next;
    logic               r_ack, w_ack_next;
    logic               r_ce_n, w_ce_n_next;
    logic               r_oe_n, w_oe_n_next;
    logic               r_we_n, w_we_n_next;
    logic               r_dq_oe, w_dq_oe_next;
    logic               w_active_next;
    logic               w_strobe_next;

    // State, latched request and registered pad controls
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_dq    <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            r_dq    <= w_dq_next;
            r_dat   <= w_dat_next;
            r_ack   <= w_ack_next;
            r_ce_n  <= w_ce_n_next;
            r_oe_n  <= w_oe_n_next;
            r_we_n  <= w_we_n_next;
            r_dq_oe <= w_dq_oe_next;
        end
    end

    // Next state plus pad controls decoded from the state being entered
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_we_next    = r_we;
        w_addr_next  = r_addr;
        w_dq_next    = r_dq;
        w_dat_next   = r_dat;

        case (r_state)
            ST_IDLE: begin
                if (i_cs) begin
                    w_addr_next  = SRAM_AW'(i_addr);
                    w_dq_next    = i_dat;
                    w_we_next    = i_we;
                    w_cnt_next   = SETUP_LOAD;
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!i_cs) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_cnt_next   = ACCESS_LOAD;
                    w_state_next = ST_ACCESS;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                if (!i_cs) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    if (!r_we) begin
                        w_dat_next   = i_sram_dq;
                        w_state_next = ST_DONE;
                    end else if (HOLD_CYCLES == 0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_cnt_next   = HOLD_LOAD;
                        w_state_next = ST_HOLD;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!i_cs) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!i_cs) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_active_next = (w_state_next == ST_SETUP) || (w_state_next == ST_ACCESS) ||
                        (w_state_next == ST_HOLD);
        w_strobe_next = (w_state_next == ST_SETUP) || (w_state_next == ST_ACCESS);
        w_ack_next    = (w_state_next == ST_DONE);
        w_ce_n_next   = !w_active_next;
        w_oe_n_next   = !(w_strobe_next && !w_we_next);
        w_we_n_next   = !((w_state_next == ST_ACCESS) && w_we_next);
        w_dq_oe_next  = w_active_next && w_we_next;
    end

    assign o_dat        = r_dat;
    assign o_ack        = r_ack;
    assign o_sram_addr  = r_addr;
    assign o_sram_dq    = r_dq;
    assign o_sram_dq_oe = r_dq_oe;
    assign o_sram_ce_n  = r_ce_n;
    assign o_sram_oe_n  = r_oe_n;
    assign o_sram_we_n  = r_we_n;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench: two responders (default timing and SETUP=2/ACCESS=4/HOLD=0)
// each with an SRAM emulation and a cycle-accurate expectation model.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_addr = '0;
    logic [7:0]  i_dat = '0;
    logic        i_we = 1'b0;
    logic [1:0]  cs = '0;
    logic [1:0]  ack, ce_n, oe_n, we_n, dq_oe;
    logic [7:0]  dat [2];
    logic [15:0] saddr [2];
    logic [7:0]  sdq [2];
    logic [7:0]  sdq_in [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int unsigned S = (g == 0) ? 1 : 2;
        localparam int unsigned A = (g == 0) ? 2 : 4;
        localparam int unsigned H = (g == 0) ? 1 : 0;

        logic [7:0]  sram [65536];
        logic [7:0]  exp_mem [65536];
        logic        m_busy, m_done, m_we;
        int          m_k;
        logic [15:0] m_addr;
        logic [7:0]  m_dq, m_dat;

        sram_responder #(
            .SRAM_AW      (16),
            .SETUP_CYCLES (S),
            .ACCESS_CYCLES(A),
            .HOLD_CYCLES  (H)
        ) u_dut (
            .i_clk       (clk),
            .i_reset     (rst),
            .i_addr      (i_addr),
            .i_dat       (i_dat),
            .o_dat       (dat[g]),
            .i_we        (i_we),
            .i_cs        (cs[g]),
            .o_ack       (ack[g]),
            .o_sram_addr (saddr[g]),
            .o_sram_dq   (sdq[g]),
            .i_sram_dq   (sdq_in[g]),
            .o_sram_dq_oe(dq_oe[g]),
            .o_sram_ce_n (ce_n[g]),
            .o_sram_oe_n (oe_n[g]),
            .o_sram_we_n (we_n[g])
        );

        // Asynchronous SRAM: drives DQ while selected and output-enabled, stores while WE_n low
        assign sdq_in[g] = (!ce_n[g] && !oe_n[g]) ? sram[saddr[g]] : 8'hEE;
        initial begin
            sram[16'h1234] = 8'hA5;
            forever begin
                @(negedge clk);
                if (!ce_n[g] && !we_n[g]) sram[saddr[g]] = sdq[g];
            end
        end

        // Transaction model: counts edges since acceptance; ack after S+A (+H for writes)
        initial begin
            exp_mem[16'h1234] = 8'hA5;
            m_busy = 1'b0; m_done = 1'b0; m_we = 1'b0; m_k = 0;
            m_addr = '0; m_dq = '0; m_dat = '0;
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    m_busy = 1'b0; m_done = 1'b0; m_we = 1'b0; m_k = 0;
                    m_addr = '0; m_dq = '0; m_dat = '0;
                end else if (m_done) begin
                    if (!cs[g]) m_done = 1'b0;
                end else if (m_busy) begin
                    if (!cs[g]) begin
                        m_busy = 1'b0;
                    end else if (m_k + 1 == int'(S + A + (m_we ? H : 0))) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        if (m_we) exp_mem[m_addr] = m_dq;
                        else m_dat = exp_mem[m_addr];
                    end else begin
                        m_k = m_k + 1;
                    end
                end else if (cs[g]) begin
                    m_busy = 1'b1; m_k = 0;
                    m_addr = i_addr; m_dq = i_dat; m_we = i_we;
                end
            end
        end

        // Per-cycle comparison of every output against the model
        initial begin : cmp_proc
            int   ph;
            logic e_ce_n, e_oe_n, e_we_n, e_dq_oe;
            forever begin
                @(negedge clk);
                ph = (m_k < int'(S)) ? 0 : (m_k < int'(S + A)) ? 1 : 2;
                if (m_busy) begin
                    e_ce_n  = 1'b0;
                    e_oe_n  = (ph < 2) ? m_we : 1'b1;
                    e_we_n  = !(ph == 1 && m_we);
                    e_dq_oe = m_we;
                end else begin
                    e_ce_n = 1'b1; e_oe_n = 1'b1; e_we_n = 1'b1; e_dq_oe = 1'b0;
                end
                cmp($sformatf("u%0d_ce_n", g), 32'(ce_n[g]), 32'(e_ce_n));
                cmp($sformatf("u%0d_oe_n", g), 32'(oe_n[g]), 32'(e_oe_n));
                cmp($sformatf("u%0d_we_n", g), 32'(we_n[g]), 32'(e_we_n));
                cmp($sformatf("u%0d_dq_oe", g), 32'(dq_oe[g]), 32'(e_dq_oe));
                cmp($sformatf("u%0d_ack", g), 32'(ack[g]), 32'(m_done));
                cmp($sformatf("u%0d_o_dat", g), 32'(dat[g]), 32'(m_dat));
                cmp($sformatf("u%0d_we_oe_excl", g), 32'(we_n[g] | oe_n[g]), 32'(1));
                cmp($sformatf("u%0d_dq_vs_oe", g), 32'(dq_oe[g] & !oe_n[g]), 32'(0));
                if (m_busy) cmp($sformatf("u%0d_addr", g), 32'(saddr[g]), 32'(m_addr));
                if (e_dq_oe) cmp($sformatf("u%0d_dq", g), 32'(sdq[g]), 32'(m_dq));
            end
        end
    end

    // One full transaction on instance i, entered and left on a negedge
    task automatic run(input int i, input logic we, input logic [15:0] a, input logic [7:0] d,
                       input int exp_lat, input int exp_lo, input int exp_dat);
        int lat;
        int lo;
        i_addr = a; i_dat = d; i_we = we; cs[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_addr = ~a; i_dat = ~d; i_we = ~we;
        lat = 0; lo = 0;
        while (!ack[i] && lat < 40) begin
            if (we ? !we_n[i] : !oe_n[i]) lo++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        cmp($sformatf("u%0d_latency_%h", i, a), 32'(lat), 32'(exp_lat));
        cmp($sformatf("u%0d_strobe_low_cycles_%h", i, a), 32'(lo), 32'(exp_lo));
        if (exp_dat >= 0) cmp($sformatf("u%0d_read_data_%h", i, a), 32'(dat[i]), 32'(exp_dat));
        @(posedge clk);
        @(negedge clk);
        cmp($sformatf("u%0d_ack_held", i), 32'(ack[i]), 32'(1));
        cs[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmp($sformatf("u%0d_ack_drop", i), 32'(ack[i]), 32'(0));
        cmp($sformatf("u%0d_ce_gap", i), 32'(ce_n[i]), 32'(1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cmp($sformatf("u%0d_rst_pads", i),
                32'({ce_n[i], oe_n[i], we_n[i], dq_oe[i], ack[i]}), 32'(5'b11100));
            cmp($sformatf("u%0d_rst_dat", i), 32'(dat[i]), 32'(0));
            cmp($sformatf("u%0d_rst_addr", i), 32'(saddr[i]), 32'(0));
            cmp($sformatf("u%0d_rst_dq", i), 32'(sdq[i]), 32'(0));
        end
        rst = 1'b0;

        // Reset raised during the ACCESS phase of a write
        i_addr = 16'h0F00; i_dat = 8'h77; i_we = 1'b1; cs[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        cmp("u0_midwrite_we_n", 32'(we_n[0]), 32'(0));
        #2 rst = 1'b1;
        #1;
        cmp("u0_async_rst_pads", 32'({ce_n[0], oe_n[0], we_n[0], dq_oe[0], ack[0]}), 32'(5'b11100));
        cmp("u0_async_rst_dat", 32'(dat[0]), 32'(0));
        cs[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run(0, 1'b0, 16'h1234, 8'h00, 3, 3, 8'hA5);
        run(0, 1'b1, 16'h00FF, 8'h3C, 4, 2, -1);
        run(0, 1'b0, 16'h00FF, 8'h00, 3, 3, 8'h3C);

        // Abort a read in its first ACCESS cycle
        i_addr = 16'h1234; i_we = 1'b0; cs[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        cmp("u0_abort_in_access", 32'(oe_n[0]), 32'(0));
        cs[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        cmp("u0_abort_idle", 32'({ce_n[0], oe_n[0], we_n[0], dq_oe[0]}), 32'(4'b1110));
        repeat (3) begin
            cmp("u0_abort_no_ack", 32'(ack[0]), 32'(0));
            cmp("u0_abort_dat_kept", 32'(dat[0]), 32'(8'h3C));
            @(posedge clk); @(negedge clk);
        end

        // Back-to-back write then read with a single idle edge between
        run(0, 1'b1, 16'h0001, 8'h11, 4, 2, -1);
        run(0, 1'b0, 16'h0001, 8'h00, 3, 3, 8'h11);

        run(1, 1'b1, 16'h0042, 8'h5A, 6, 4, -1);
        run(1, 1'b0, 16'h0042, 8'h00, 6, 6, 8'h5A);
        run(1, 1'b0, 16'h1234, 8'h00, 6, 6, 8'hA5);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Bus slave sitting on the system memory bus (addr / dat / we / cs / ack) driven by the CPU and the UART master.
- Turns each bus request into a timed asynchronous-SRAM read or write cycle on an external 8-bit SRAM.
- Returns a level acknowledge: high once the cycle completes, held until the master drops cs. This maps directly onto the CPU wait_n logic.
- Setup, access and hold times are parameterised in clock cycles.

Parameters:
- SRAM_AW, 16, SRAM address width; bus address is zero-extended or truncated to this.
- SETUP_CYCLES, 1, cycles from address/CE valid to strobe assertion (1..15).
- ACCESS_CYCLES, 2, cycles OE_n/WE_n is held low (1..15).
- HOLD_CYCLES, 1, write data hold after WE_n rises (0..15; 0 skips HOLD).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_addr  in  16  bus address
- i_dat  in  8  write data from master
- o_dat  out  8  read data to master
- i_we  in  1  1 = write, 0 = read; valid with i_cs
- i_cs  in  1  bus request, held by master until o_ack seen
- o_ack  out  1  transaction complete (level)
- o_sram_addr  out  SRAM_AW  SRAM address
- o_sram_dq  out  8  SRAM write data
- i_sram_dq  in  8  SRAM read data
- o_sram_dq_oe  out  1  1 = drive DQ pads with o_sram_dq
- o_sram_ce_n  out  1  chip enable, active low
- o_sram_oe_n  out  1  output enable, active low
- o_sram_we_n  out  1  write enable, active low

Behaviour:
- Reset (async, immediate), also forced mid-cycle if i_reset rises:
  - state IDLE, o_ack=0, o_dat=0
  - o_sram_ce_n=1, o_sram_oe_n=1, o_sram_we_n=1, o_sram_dq_oe=0
  - o_sram_addr=0, o_sram_dq=0
- States: IDLE, SETUP, ACCESS, HOLD, DONE. One 4-bit down counter cnt; reloaded on every state entry with (param-1).
- IDLE:
  - All strobes high; o_ack=0.
  - On a posedge with i_cs=1: latch i_addr into o_sram_addr, i_dat into o_sram_dq, and i_we into an internal we_r; load cnt; go to SETUP.
- SETUP (SETUP_CYCLES cycles):
  - ce_n=0. For writes dq_oe=1. For reads oe_n=0 (OE asserted with CE for reads).
  - When cnt reaches 0, go to ACCESS.
- ACCESS (ACCESS_CYCLES cycles):
  - ce_n=0. Write: we_n=0, dq_oe=1. Read: oe_n=0.
  - At cnt==0, read path: o_dat <= i_sram_dq on that edge, then go to DONE.
  - At cnt==0, write path: go to HOLD, or to DONE if HOLD_CYCLES==0.
- HOLD (writes only, HOLD_CYCLES cycles):
  - ce_n=0, we_n=1, dq_oe=1.
  - When cnt reaches 0, go to DONE.
- DONE:
  - o_ack=1 (registered), all strobes high, dq_oe=0, o_dat stable.
  - While i_cs=1, stay in DONE.
  - When i_cs=0, go to IDLE with o_ack=0 on the next edge. This guarantees at least one CE-high cycle between accesses.
- Latency: ack is high N edges after the edge that sampled i_cs.
  - Read: N = SETUP+ACCESS (defaults: 3).
  - Write: N = SETUP+ACCESS+HOLD (defaults: 4).
- Abort: if i_cs=0 while in SETUP, ACCESS or HOLD:
  - Next edge goes to IDLE with all strobes high and dq_oe=0.
  - No ack is issued and o_dat is unchanged.
  - The SRAM write may be partial; this is defined as the master's fault.
- Inputs and we_r are latched once in IDLE. Changes to i_addr, i_dat or i_we during a transaction are ignored.
- WE_n and OE_n are never low simultaneously. dq_oe is never 1 while oe_n is 0.
- Back-to-back requests: a new request is accepted only from IDLE, so i_cs must be low for at least one edge between transactions.
- Address width: SRAM_AW<16 takes i_addr[SRAM_AW-1:0]; SRAM_AW>16 zero-pads the upper bits.

Test Plan:
- Reset: assert i_reset mid-ACCESS of a write -> we_n, ce_n and oe_n go high and dq_oe=0 immediately (no clock edge), o_ack=0.
- Read (defaults): preload SRAM model at 0x1234 with 0xA5; i_cs=1, i_we=0, i_addr=0x1234 -> oe_n low 3 cycles, o_ack=1 3 edges after sample, o_dat=0xA5. o_ack is held while i_cs=1 and drops 1 edge after i_cs=0.
- Write (defaults): i_addr=0x00FF, i_dat=0x3C, i_we=1 -> we_n low exactly 2 cycles, dq=0x3C valid from SETUP through HOLD, o_ack after 4 edges; a read of 0x00FF returns 0x3C.
- Timing params: SETUP=2, ACCESS=4, HOLD=0 -> write ack after 6 edges with no HOLD cycle; read ack after 6 edges.
- Abort: drop i_cs in the 1st ACCESS cycle of a read -> IDLE next edge, o_ack never asserts, o_dat keeps its previous value.
- Back-to-back: write 0x11 to 0x0001, drop i_cs for 1 cycle, read 0x0001 -> ce_n high at least 1 cycle between accesses, read returns 0x11, no strobe overlap in either cycle.
